// File: rtl/ins_mem_loader_pkg.sv
// Shared constants for the instruction memory boot loader: FSM encoding,
// byte/word geometry and the NOP word presented to the core while held in reset.
package ins_mem_loader_pkg;

    // Loader state register type and encoding
    typedef logic [1:0] loader_state_t;

    localparam loader_state_t ST_IDLE = 2'd0;
    localparam loader_state_t ST_LOAD = 2'd1;
    localparam loader_state_t ST_RUN  = 2'd2;

    // Default instruction geometry; the loader itself derives its byte count
    // from its WIDTH parameter through bytes_per_word().
    localparam int DEFAULT_WIDTH  = 32;
    localparam int BYTES_PER_WORD = DEFAULT_WIDTH / 8;

    // The core decodes opcode 4'b0000 as NOP, so an all-zero word is a NOP.
    // It is sized generously so any legal WIDTH can take a slice of it.
    localparam int                   MAX_WIDTH  = 1024;
    localparam logic [3:0]           NOP_OPCODE = 4'b0000;
    localparam logic [MAX_WIDTH-1:0] NOP_WORD   = '0;

    // Number of program bytes that make up one instruction word
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/ins_mem_loader_ram.sv
// Instruction RAM: one synchronous write port driven by the loader and one
// asynchronous read port serving the core's fetch address. No control logic.
module ins_ram
    import ins_mem_loader_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Write the assembled word on the edge that accepts its last byte
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ins_mem_loader.sv
// Instruction memory with a big-endian byte-stream boot loader. While a load
// is in progress the core is held in reset and sees NOP; once the requested
// number of words has been written the core is released and the RAM becomes
// a read-only fetch port until the next load command.
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_start,
    input  logic [ADDRSIZE:0]   ld_len,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic [ADDRSIZE-1:0] INS_ADDR,
    output logic [0:WIDTH-1]    INS_MEM,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int BPW = bytes_per_word(WIDTH);
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BPW - 1);
    localparam logic [BCW-1:0]      BYTE_ONE  = BCW'(1);
    localparam logic [ADDRSIZE-1:0] ADDR_ONE  = ADDRSIZE'(1);
    localparam logic [ADDRSIZE:0]   WORD_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE:0]   MAX_LEN   = {1'b1, {ADDRSIZE{1'b0}}};

    loader_state_t       state;
    logic [ADDRSIZE:0]   len_q;
    logic [ADDRSIZE:0]   word_cnt;
    logic [ADDRSIZE-1:0] wr_addr;
    logic [BCW-1:0]      byte_cnt;
    logic [WIDTH-1:0]    hold_q;
    logic [WIDTH-1:0]    wr_word;
    logic [WIDTH-1:0]    rd_word;

    logic cmd_window;
    logic len_ok;
    logic start_ok;
    logic start_bad;
    logic accept;
    logic word_last;
    logic load_last;

    // Load commands are only honoured outside LOAD; a length of zero or more
    // words than the RAM holds is rejected without leaving the current state.
    assign cmd_window = (state == ST_IDLE) || (state == ST_RUN);
    assign len_ok     = (ld_len != '0) && (ld_len <= MAX_LEN);
    assign start_ok   = cmd_window && ld_start && len_ok;
    assign start_bad  = cmd_window && ld_start && !len_ok;

    // The loader is always ready in LOAD, so every valid byte is taken.
    assign byte_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD);
    assign accept     = byte_ready && byte_valid;

    // The final byte of a word completes it; the word count, not the write
    // address, decides when the whole program has arrived (the address wraps
    // on a full-depth load).
    assign word_last  = accept && (byte_cnt == LAST_BYTE);
    assign load_last  = word_last && ((word_cnt + WORD_ONE) == len_q);

    // Earlier bytes sit in the low end of hold_q and move up by one byte per
    // accepted byte, so the first byte lands in the most significant byte,
    // which maps onto INS_MEM[0:7] (opcode and condition code).
    assign wr_word = (hold_q << 8) | WIDTH'(byte_in);

    // Control: state, core reset, latched length and the one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cpu_rst <= 1'b1;
            len_q   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= load_last;
            err  <= start_bad;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (start_ok) begin
                        state   <= ST_LOAD;
                        cpu_rst <= 1'b1;
                        len_q   <= ld_len;
                    end
                end
                ST_LOAD: begin
                    if (load_last) begin
                        state   <= ST_RUN;
                        cpu_rst <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

    // Datapath: byte assembly, write address and words-written counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            hold_q   <= '0;
            wr_addr  <= '0;
            word_cnt <= '0;
        end else if (start_ok) begin
            byte_cnt <= '0;
            hold_q   <= '0;
            wr_addr  <= '0;
            word_cnt <= '0;
        end else if (accept) begin
            if (word_last) begin
                byte_cnt <= '0;
                hold_q   <= '0;
                wr_addr  <= wr_addr + ADDR_ONE;
                word_cnt <= word_cnt + WORD_ONE;
            end else begin
                byte_cnt <= byte_cnt + BYTE_ONE;
                hold_q   <= wr_word;
            end
        end
    end

    ins_ram #(
        .WIDTH    (WIDTH),
        .ADDRSIZE (ADDRSIZE)
    ) u_ram (
        .clk   (clk),
        .we    (word_last),
        .waddr (wr_addr),
        .wdata (wr_word),
        .raddr (INS_ADDR),
        .rdata (rd_word)
    );

    // A core held in reset must only ever see NOP on its fetch port.
    assign INS_MEM = cpu_rst ? NOP_WORD[WIDTH-1:0] : rd_word;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: a transaction-level model (byte
// queue, word array, load/run flags) is advanced on every clock edge and a
// single compare process checks all outputs against it on every falling edge.
module tb_ins_mem_loader;

    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;
    localparam int DEPTH    = 1 << ADDRSIZE;
    localparam int LW       = ADDRSIZE + 1;

    logic                clk        = 1'b0;
    logic                rst        = 1'b0;
    logic                ld_start   = 1'b0;
    logic [ADDRSIZE:0]   ld_len     = '0;
    logic [7:0]          byte_in    = '0;
    logic                byte_valid = 1'b0;
    logic                byte_ready;
    logic [ADDRSIZE-1:0] INS_ADDR   = '0;
    logic [0:WIDTH-1]    INS_MEM;
    logic                cpu_rst;
    logic                busy;
    logic                done;
    logic                err;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    bit rand_addr = 1'b0;

    // Reference model state
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_valid [DEPTH];
    logic [7:0]  mdl_q[$];
    bit          mdl_loading = 1'b0;
    logic        mdl_cpu_rst = 1'b1;
    logic        mdl_done    = 1'b0;
    logic        mdl_err     = 1'b0;
    int          mdl_target  = 0;
    int          mdl_written = 0;
    int          mdl_addr    = 0;

    ins_mem_loader #(
        .WIDTH    (WIDTH),
        .ADDRSIZE (ADDRSIZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_start   (ld_start),
        .ld_len     (ld_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .INS_ADDR   (INS_ADDR),
        .INS_MEM    (INS_MEM),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a program is a byte stream cut into 4-byte big-endian words
    always @(posedge clk or posedge rst) begin
        logic [31:0] w;
        int          l;
        if (rst) begin
            mdl_loading = 1'b0;
            mdl_cpu_rst = 1'b1;
            mdl_done    = 1'b0;
            mdl_err     = 1'b0;
            mdl_q.delete();
        end else begin
            mdl_done = 1'b0;
            mdl_err  = 1'b0;
            if (mdl_loading) begin
                if (byte_valid) begin
                    mdl_q.push_back(byte_in);
                    if (mdl_q.size() == WIDTH / 8) begin
                        w = '0;
                        foreach (mdl_q[i]) w = (w << 8) | 32'(mdl_q[i]);
                        mdl_q.delete();
                        mdl_mem[mdl_addr]   = w;
                        mdl_valid[mdl_addr] = 1'b1;
                        mdl_addr            = (mdl_addr + 1) % DEPTH;
                        mdl_written++;
                        if (mdl_written == mdl_target) begin
                            mdl_loading = 1'b0;
                            mdl_cpu_rst = 1'b0;
                            mdl_done    = 1'b1;
                        end
                    end
                end
            end else if (ld_start) begin
                l = int'(ld_len);
                if (l >= 1 && l <= DEPTH) begin
                    mdl_loading = 1'b1;
                    mdl_cpu_rst = 1'b1;
                    mdl_target  = l;
                    mdl_written = 0;
                    mdl_addr    = 0;
                    mdl_q.delete();
                end else begin
                    mdl_err = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        checkOutput("cpu_rst", 32'(cpu_rst), 32'(mdl_cpu_rst));
        checkOutput("byte_ready", 32'(byte_ready), 32'(mdl_loading));
        checkOutput("busy", 32'(busy), 32'(mdl_loading));
        checkOutput("done", 32'(done), 32'(mdl_done));
        checkOutput("err", 32'(err), 32'(mdl_err));
        if (mdl_cpu_rst)
            checkOutput("ins_nop", INS_MEM, 32'h0);
        else if (mdl_valid[INS_ADDR])
            checkOutput("ins_mem", INS_MEM, mdl_mem[INS_ADDR]);
    end

    // Bytes the DUT will take on the next rising edge
    always @(negedge clk) begin
        if (byte_valid && byte_ready && !rst) acc_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_addr) INS_ADDR = ADDRSIZE'($urandom_range(0, 7));
    endtask

    task automatic startLoad(input int len);
        ld_start = 1'b1;
        ld_len   = LW'(len);
        tick();
        ld_start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gaps);
        repeat (gaps) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            tick();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic readWord(input int addr, input string name, input logic [31:0] exp);
        INS_ADDR = ADDRSIZE'(addr);
        #1;
        checkOutput(name, INS_MEM, exp);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  b2 [12];
        logic [7:0]  bw [4];
        logic [31:0] w2 [3];
        logic [31:0] nw;
        int          start_acc;
        int          len;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("reset_byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ins_nop", INS_MEM, 32'h0);

        // Single HLT word, back-to-back bytes
        $display("[TB] load of one HLT word");
        startLoad(1);
        bw[0] = 8'h90; bw[1] = 8'h00; bw[2] = 8'h00; bw[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bw[i], 0);
            if (i == 2) checkOutput("hlt_done_early", 32'(done), 32'd0);
        end
        checkOutput("hlt_done", 32'(done), 32'd1);
        checkOutput("hlt_cpu_rst", 32'(cpu_rst), 32'd0);
        readWord(0, "hlt_word", 32'h90000000);

        // Three words with byte_valid toggling
        $display("[TB] three-word load with gaps");
        start_acc = acc_cnt;
        startLoad(3);
        for (int i = 0; i < 12; i++) begin
            b2[i] = 8'($urandom);
            applyStimulus(b2[i], 1);
        end
        checkOutput("gap_done", 32'(done), 32'd1);
        checkOutput("gap_accepted", 32'(acc_cnt - start_acc), 32'd12);
        for (int k = 0; k < 3; k++) begin
            w2[k] = {b2[4*k], b2[4*k+1], b2[4*k+2], b2[4*k+3]};
            readWord(k, "gap_word", w2[k]);
        end

        // Illegal lengths from RUN
        $display("[TB] illegal lengths in RUN");
        startLoad(0);
        checkOutput("err_zero", 32'(err), 32'd1);
        checkOutput("err_zero_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("err_zero_ready", 32'(byte_ready), 32'd0);
        tick();
        checkOutput("err_pulse_end", 32'(err), 32'd0);
        startLoad(DEPTH + 1);
        checkOutput("err_big", 32'(err), 32'd1);
        tick();

        // Reset in the middle of a two-word load
        $display("[TB] reset during load");
        startLoad(2);
        for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), 0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("midrst_ready", 32'(byte_ready), 32'd0);
        checkOutput("midrst_ins_nop", INS_MEM, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        startLoad(0);
        checkOutput("err_idle", 32'(err), 32'd1);
        checkOutput("err_idle_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();

        // One fresh word: the half-written word 1 must still be the old one
        startLoad(1);
        for (int i = 0; i < 4; i++) begin
            bw[i] = 8'($urandom);
            applyStimulus(bw[i], $urandom_range(0, 2));
        end
        checkOutput("fresh_done", 32'(done), 32'd1);
        readWord(0, "fresh_word0", {bw[0], bw[1], bw[2], bw[3]});
        readWord(1, "kept_word1", w2[1]);
        readWord(2, "kept_word2", w2[2]);
        for (int a = 0; a < 4; a++) begin
            INS_ADDR = ADDRSIZE'(a);
            tick();
        end

        // Restart from RUN
        $display("[TB] restart from RUN");
        startLoad(1);
        checkOutput("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("restart_ins_nop", INS_MEM, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bw[i] = 8'($urandom);
            applyStimulus(bw[i], $urandom_range(0, 3));
        end
        nw = {bw[0], bw[1], bw[2], bw[3]};
        checkOutput("restart_cpu_rst_low", 32'(cpu_rst), 32'd0);
        readWord(0, "restart_word", nw);

        // Randomised loads, stray commands during LOAD, random fetches
        $display("[TB] random loads");
        rand_addr = 1'b1;
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(1, 8);
            startLoad(len);
            for (int i = 0; i < 4 * len; i++) begin
                ld_start = ($urandom_range(0, 5) == 0);
                ld_len   = LW'($urandom);
                applyStimulus(8'($urandom), $urandom_range(0, 2));
                ld_start = 1'b0;
            end
            checkOutput("rand_done", 32'(done), 32'd1);
            repeat ($urandom_range(3, 10)) tick();
            if ($urandom_range(0, 1) == 1) begin
                startLoad(($urandom_range(0, 1) == 1) ? 0 : DEPTH + 1 + $urandom_range(0, 100));
                tick();
            end
        end
        rand_addr = 1'b0;

        // Full-depth load of an incrementing byte pattern
        $display("[TB] full-depth load");
        start_acc = acc_cnt;
        startLoad(DEPTH);
        for (int j = 0; j < 4 * DEPTH; j++) applyStimulus(8'(j), 0);
        checkOutput("full_done", 32'(done), 32'd1);
        checkOutput("full_accepted", 32'(acc_cnt - start_acc), 32'(4 * DEPTH));
        readWord(0, "full_addr0", 32'h00010203);
        readWord(5, "full_addr5", 32'h14151617);
        readWord(DEPTH - 1, "full_addr_last", 32'hfcfdfeff);
        for (int a = 0; a < DEPTH; a++) begin
            INS_ADDR = ADDRSIZE'(a);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ins_mem_loader.md
# ins_mem_loader

Instruction memory with a byte-stream boot loader, sitting directly upstream of `instruction_set_model`. It owns the 2^ADDRSIZE x WIDTH instruction RAM and serves the core's `INS_ADDR`/`INS_MEM` fetch port. It accepts a program as a big-endian byte stream over a valid/ready handshake and holds the core in reset until the requested number of words has been written. After loading, it releases the core and acts as a read-only instruction memory until the next load command.

## Interface

Parameters:
- `WIDTH`, 32, instruction width in bits; must be a multiple of 8.
- `ADDRSIZE`, 12, instruction address width; the RAM depth is 2^ADDRSIZE words.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ld_start`  in  1  one-cycle load command; sampled in IDLE and RUN only.
- `ld_len`  in  ADDRSIZE+1  number of words to load, sampled with `ld_start`; legal range 1..2^ADDRSIZE.
- `byte_in`  in  8  program byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  the loader accepts a byte this cycle.
- `INS_ADDR`  in  ADDRSIZE  fetch address from the core.
- `INS_MEM`  out  [0:WIDTH-1]  fetched instruction, combinational from `INS_ADDR`.
- `cpu_rst`  out  1  reset to the core, active-high.
- `busy`  out  1  high in LOAD.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle pulse when `ld_len` is illegal.

## Operation

- States: IDLE, LOAD, RUN.
- Reset values: state IDLE, `cpu_rst`=1, `byte_ready`=0, `busy`=0, `done`=0, `err`=0. The write address, byte counter and word counter are 0. RAM contents are not reset.
- IDLE or RUN with `ld_start`=1:
  - If `ld_len` is 0 or greater than 2^ADDRSIZE, pulse `err` and stay in the current state. RUN keeps `cpu_rst`=0.
  - Otherwise, latch `ld_len`, clear the counters, go to LOAD and set `cpu_rst`=1 on the same edge.
- LOAD:
  - `byte_ready`=1 and `busy`=1. `ld_start` is ignored.
  - A byte is accepted on each edge where `byte_valid & byte_ready`.
  - Byte order is big-endian: the first byte of a word fills `INS_MEM[0:7]`, which is the opcode and condition-code field; the last byte fills `INS_MEM[WIDTH-8:WIDTH-1]`.
  - On the edge that accepts the last byte of a word, the assembled word (held bytes plus `byte_in`) is written to the RAM at the write address. The write address then increments, wrapping within ADDRSIZE bits.
  - On the edge that writes word number `ld_len`, go to RUN, clear `cpu_rst` and `byte_ready`, and pulse `done` for one cycle.
- RUN: `cpu_rst`=0, `byte_ready`=0.
- Fetch port: while `cpu_rst`=1, `INS_MEM` reads as all-zero (NOP). Otherwise, `INS_MEM` = RAM[`INS_ADDR`].
- Words at addresses at or above `ld_len` keep their previous contents.
- A partial word left when `rst` is asserted is discarded.

## Timing

- Load throughput: one byte per cycle when `byte_valid` is held high; WIDTH/8 cycles per word.
- Gaps in `byte_valid` stall the loader with no loss of data.
- Write latency: the RAM holds the new word after the accepting edge, with no extra cycle.
- `cpu_rst` falls on the same edge as the final write. The core's first unreset edge fetches address 0 and sees the loaded word.
- Restart from RUN: `cpu_rst` rises on the `ld_start` edge. The core is in reset from the next cycle on.
- `rst` asserted mid-load: all state returns to the reset values immediately and asynchronously. Words already written stay in RAM.
- `ld_len` = 2^ADDRSIZE: the write address wraps to 0 on the final increment. This is harmless, because the word count, not the address, ends the load.

## Structure

- Shared package holds:
  - the state encoding (IDLE=0, LOAD=1, RUN=2);
  - the `BYTES_PER_WORD` = WIDTH/8 constant;
  - the NOP word constant (all zero), which matches the core's NOP opcode 4'b0000.
- Sub-module `ins_ram`: a single-port-write, asynchronous-read array with parameters WIDTH and ADDRSIZE, holding no control logic.
- All handshake logic and counters live in the top level.

## Test plan

- Reset, then `ld_start` with `ld_len`=1 and bytes 0x90,0x00,0x00,0x00 back-to-back. Expect: `done` pulses 4 cycles after the first byte, `cpu_rst` falls on the same edge, and `INS_MEM` at `INS_ADDR`=0 reads 0x90000000 (HLT).
- `ld_len`=3, 12 bytes with `byte_valid` toggling every other cycle. Expect: exactly 12 accepted bytes, words 0..2 correct, `done` only after the 12th accepted byte.
- `ld_len`=0 and separately `ld_len`=4097. Expect: `err` pulses for one cycle, state is unchanged, `byte_ready` stays 0.
- `rst` asserted after 6 bytes of a 2-word load. Expect: word 0 stored, word 1 not written, `cpu_rst`=1, `byte_ready`=0, and `INS_MEM`=0 while in reset.
- `ld_len`=4096 full load of an incrementing pattern. Expect: every address correct, `done` after 16384 accepted bytes.
- In RUN, issue `ld_start` with `ld_len`=1 and a new word. Expect: `cpu_rst` high from the command edge until the new word is written, then address 0 holds the new word.
